// File: rtl/cfg_serial_master.sv
// cfg_serial_master: serialises parallel register write/read requests onto the
// 3-wire configuration slave interface (strobe, wr_en, din) and collects the
// slave's serial read response (dout) into a parallel result.
// DATA_BITS must be at least 3 (the capture shifter keeps DATA_BITS-1 bits).
module cfg_serial_master #(
    parameter int ADDR_BITS     = 5,
    parameter int DATA_BITS     = 8,
    parameter int RD_TURNAROUND = 2,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 busy,
    output logic                 ser_strobe,
    output logic                 ser_wr_en,
    output logic                 ser_din,
    input  logic                 ser_dout
);

    localparam int N      = DATA_BITS + ADDR_BITS;
    localparam int MAX_NT = (N > RD_TURNAROUND) ? N : RD_TURNAROUND;
    localparam int MAX_C  = (MAX_NT > GAP_CYCLES) ? MAX_NT : GAP_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] WR_LAST   = CW'(N - 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BITS - 1);
    localparam logic [CW-1:0] TURN_LAST = CW'(RD_TURNAROUND - 1);
    localparam logic [CW-1:0] CAP_LAST  = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_TURN    = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_GAP     = 3'd6;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 write_q;
    logic [N-1:0]         tx_q;
    logic [DATA_BITS-2:0] rx_q;
    logic [DATA_BITS-1:0] rdata_q;
    logic                 init_q;    // low until the first edge after reset release
    logic                 accept;
    logic                 counting;

    assign req_ready  = (state_q == ST_IDLE) && init_q;
    assign accept     = req_valid && req_ready;
    assign busy       = (state_q != ST_IDLE);
    assign ser_strobe = (state_q == ST_START);
    assign ser_din    = (state_q == ST_SHIFT) && tx_q[0];
    assign rsp_valid  = (state_q == ST_DONE);
    assign ser_wr_en  = write_q;
    assign rsp_rdata  = rdata_q;

    // Next-state decode; unknown encodings fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = ST_START;
            ST_START:   state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (write_q && cnt_q == WR_LAST)         state_d = ST_DONE;
                else if (!write_q && cnt_q == ADDR_LAST) state_d = ST_TURN;
            end
            ST_TURN:    if (cnt_q == TURN_LAST) state_d = ST_CAPTURE;
            ST_CAPTURE: if (cnt_q == CAP_LAST)  state_d = ST_DONE;
            ST_DONE:    state_d = ST_GAP;
            ST_GAP:     if (cnt_q == GAP_LAST)  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Shared bit counter: clears on every state change, counts in timed states.
    always_comb begin
        counting = (state_q == ST_SHIFT) || (state_q == ST_TURN) ||
                   (state_q == ST_CAPTURE) || (state_q == ST_GAP);
        cnt_d    = '0;
        if (counting && state_d == state_q) cnt_d = cnt_q + CW'(1);
    end

    // State, request latch, transmit/receive shifters and read result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b1;
            if (accept) begin
                // ser_wr_en keeps this value until the next accepted request.
                write_q <= req_write;
                tx_q    <= req_write ? {req_addr, req_wdata} : N'(req_addr);
            end else if (state_q == ST_SHIFT) begin
                tx_q <= tx_q >> 1;
            end
            if (state_q == ST_CAPTURE) begin
                rx_q <= {ser_dout, rx_q[DATA_BITS-2:1]};
                // Last capture edge: final bit goes straight into the result.
                if (cnt_q == CAP_LAST) rdata_q <= {ser_dout, rx_q};
            end
        end
    end

endmodule

// File: tb/tb_cfg_serial_master.sv
// Directed bench for cfg_serial_master: default instance plus a swept-parameter one.
module tb_cfg_serial_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready, rsp_valid, busy, ser_strobe, ser_wr_en, ser_din;
    logic [7:0]  rsp_rdata;
    logic        ser_dout = 1'b0;

    logic        req_valid2 = 1'b0, req_write2 = 1'b0;
    logic [5:0]  req_addr2 = '0;
    logic [15:0] req_wdata2 = '0;
    logic        req_ready2, rsp_valid2, busy2, ser_strobe2, ser_wr_en2, ser_din2;
    logic [15:0] rsp_rdata2;
    logic        ser_dout2 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cfg_serial_master dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .ser_strobe(ser_strobe), .ser_wr_en(ser_wr_en), .ser_din(ser_din),
        .ser_dout(ser_dout)
    );

    cfg_serial_master #(
        .ADDR_BITS(6), .DATA_BITS(16), .RD_TURNAROUND(3), .GAP_CYCLES(1)
    ) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_write(req_write2), .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .busy(busy2),
        .ser_strobe(ser_strobe2), .ser_wr_en(ser_wr_en2), .ser_din(ser_din2),
        .ser_dout(ser_dout2)
    );

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({req_ready, rsp_valid, busy, ser_strobe, ser_wr_en, ser_din} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b required 000000",
                     {req_ready, rsp_valid, busy, ser_strobe, ser_wr_en, ser_din});
        end
        n_checks++;
        if (rsp_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rdata got %h required 00", rsp_rdata);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge got %b required 0", req_ready);
        end
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_release got ready=%b busy=%b required 1/0",
                     req_ready, busy);
        end
    endtask

    // seq bit k is the k-th serial bit expected on ser_din
    task automatic test_write(input logic [4:0] addr, input logic [7:0] data,
                              input logic [12:0] seq, input logic [7:0] prev_rdata);
        logic e;
        @(posedge clk);
        #1 req_write = 1'b1; req_addr = addr; req_wdata = data; req_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_accept_ready got %b required 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            e = (c == 1);
            n_checks++;
            if (ser_strobe !== e) begin
                n_fail++;
                $display("FAIL write_strobe T+%0d got %b required %b", c, ser_strobe, e);
            end
            n_checks++;
            if (ser_wr_en !== 1'b1) begin
                n_fail++;
                $display("FAIL write_wr_en T+%0d got %b required 1", c, ser_wr_en);
            end
            e = (c >= 2 && c <= 14) ? seq[c-2] : 1'b0;
            n_checks++;
            if (ser_din !== e) begin
                n_fail++;
                $display("FAIL write_din T+%0d got %b required %b", c, ser_din, e);
            end
            e = (c == 15);
            n_checks++;
            if (rsp_valid !== e) begin
                n_fail++;
                $display("FAIL write_rsp_valid T+%0d got %b required %b", c, rsp_valid, e);
            end
            e = (c == 18);
            n_checks++;
            if (req_ready !== e || busy !== ~e) begin
                n_fail++;
                $display("FAIL write_ready_busy T+%0d got %b/%b required %b/%b",
                         c, req_ready, busy, e, ~e);
            end
            if (c == 15) begin
                n_checks++;
                if (rsp_rdata !== prev_rdata) begin
                    n_fail++;
                    $display("FAIL write_rdata_hold got %h required %h", rsp_rdata, prev_rdata);
                end
            end
        end
    endtask

    task automatic test_read(input logic [4:0] addr, input logic [4:0] seq,
                             input logic [7:0] val);
        logic e;
        @(posedge clk);
        #1 req_write = 1'b0; req_addr = addr; req_wdata = 8'hFF; req_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL read_accept_ready got %b required 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            e = (c == 1);
            n_checks++;
            if (ser_strobe !== e || ser_wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL read_strobe_wr_en T+%0d got %b/%b required %b/0",
                         c, ser_strobe, ser_wr_en, e);
            end
            e = (c >= 2 && c <= 6) ? seq[c-2] : 1'b0;
            n_checks++;
            if (ser_din !== e) begin
                n_fail++;
                $display("FAIL read_din T+%0d got %b required %b", c, ser_din, e);
            end
            e = (c == 17);
            n_checks++;
            if (rsp_valid !== e) begin
                n_fail++;
                $display("FAIL read_rsp_valid T+%0d got %b required %b", c, rsp_valid, e);
            end
            if (c == 17) begin
                n_checks++;
                if (rsp_rdata !== val) begin
                    n_fail++;
                    $display("FAIL read_rdata got %h required %h", rsp_rdata, val);
                end
            end
            e = (c == 20);
            n_checks++;
            if (req_ready !== e) begin
                n_fail++;
                $display("FAIL read_ready T+%0d got %b required %b", c, req_ready, e);
            end
            // Slave data only inside the capture window; 1s elsewhere expose skew.
            ser_dout = (c >= 9 && c <= 16) ? val[c-9] : 1'b1;
        end
        ser_dout = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] val;
        logic       e;
        int         r;
        val = 8'h5A;
        @(posedge clk);
        #1 req_write = 1'b1; req_addr = 5'd2; req_wdata = 8'hA5; req_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_ready got %b required 1", req_ready);
        end
        @(posedge clk);
        #1 req_write = 1'b0; req_addr = 5'd3;
        for (int c = 1; c <= 38; c++) begin
            @(negedge clk);
            r = c - 18;
            if (c <= 18) begin
                e = (c == 18);
                n_checks++;
                if (req_ready !== e) begin
                    n_fail++;
                    $display("FAIL b2b_ready T+%0d got %b required %b", c, req_ready, e);
                end
                n_checks++;
                if (ser_wr_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_wr_en_hold T+%0d got %b required 1", c, ser_wr_en);
                end
            end
            if (c >= 15 && c <= 18) begin
                n_checks++;
                if (ser_strobe !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_no_strobe T+%0d got %b required 0", c, ser_strobe);
                end
            end
            if (c == 15) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hCC) begin
                    n_fail++;
                    $display("FAIL b2b_write_done got %b/%h required 1/cc", rsp_valid, rsp_rdata);
                end
            end
            if (c == 19) begin
                n_checks++;
                if (ser_strobe !== 1'b1 || ser_wr_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_read_start got %b/%b required 1/0", ser_strobe, ser_wr_en);
                end
                req_valid = 1'b0;
            end
            if (r == 17) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== val) begin
                    n_fail++;
                    $display("FAIL b2b_read_done got %b/%h required 1/%h",
                             rsp_valid, rsp_rdata, val);
                end
            end
            if (c == 38) begin
                n_checks++;
                if (req_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_final_ready got %b required 1", req_ready);
                end
            end
            ser_dout = (r >= 9 && r <= 16) ? val[r-9] : 1'b1;
        end
        ser_dout = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        @(posedge clk);
        #1 req_write = 1'b1; req_addr = 5'd2; req_wdata = 8'hA5; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        // T+1 .. T+6; bit 4 is on the wire in T+6
        repeat (6) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || ser_din !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_pre got busy=%b din=%b required 1/0", busy, ser_din);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, busy, ser_strobe, ser_wr_en, ser_din} !== 6'b0
            || rsp_rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_outputs got %b rdata %h required 000000 rdata 00",
                     {req_ready, rsp_valid, busy, ser_strobe, ser_wr_en, ser_din}, rsp_rdata);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_held c=%0d got %b/%b required 0/0", c, rsp_valid, busy);
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_no_rsp c=%0d got %b required 0", c, rsp_valid);
            end
        end
        // addr 7, data 3C: din 0,0,1,1,1,1,0,0, 1,1,1,0,0
        test_write(5'd7, 8'h3C, 13'b0011100111100, 8'h00);
    endtask

    task automatic test_param_sweep;
        logic [15:0] val;
        logic [5:0]  seq;
        logic        e;
        val = 16'hBEEF;
        seq = 6'b010101;   // address 6'h15, LSB first 1,0,1,0,1,0
        @(posedge clk);
        #1 req_write2 = 1'b0; req_addr2 = 6'h15; req_valid2 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready2 !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_accept_ready got %b required 1", req_ready2);
        end
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        for (int c = 1; c <= 29; c++) begin
            @(negedge clk);
            e = (c >= 2 && c <= 7) ? seq[c-2] : 1'b0;
            n_checks++;
            if (ser_din2 !== e) begin
                n_fail++;
                $display("FAIL sweep_din T+%0d got %b required %b", c, ser_din2, e);
            end
            e = (c == 27);
            n_checks++;
            if (rsp_valid2 !== e) begin
                n_fail++;
                $display("FAIL sweep_rsp_valid T+%0d got %b required %b", c, rsp_valid2, e);
            end
            if (c == 27) begin
                n_checks++;
                if (rsp_rdata2 !== val) begin
                    n_fail++;
                    $display("FAIL sweep_rdata got %h required %h", rsp_rdata2, val);
                end
            end
            e = (c == 29);
            n_checks++;
            if (req_ready2 !== e) begin
                n_fail++;
                $display("FAIL sweep_ready T+%0d got %b required %b", c, req_ready2, e);
            end
            ser_dout2 = (c >= 11 && c <= 26) ? val[c-11] : 1'b1;
        end
        ser_dout2 = 1'b0;
    endtask

    initial begin
        test_reset();
        // addr 2, data A5: din 1,0,1,0,0,1,0,1, 0,1,0,0,0
        test_write(5'd2, 8'hA5, 13'b0001010100101, 8'h00);
        // addr 3: din 1,1,0,0,0
        test_read(5'd3, 5'b00011, 8'hCC);
        test_back_to_back();
        test_reset_mid_frame();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cfg_serial_master.md
# cfg_serial_master

Upstream driver for the serial configuration register slave. Accepts one parallel register write or read request at a time and serialises it onto the slave's 3-wire interface (`strobe`, `wr_en`, `din`). For reads it captures the slave's serial `dout` response and returns the register value in parallel. It sits between the on-chip controller or test logic and the SerDes configuration register file.

## Interface
Parameters:
- `ADDR_BITS`, 5: width of the serial address field; equals the slave's `ADDR_WIDTH`+1.
- `DATA_BITS`, 8: register width; equals the slave's `REG_WIDTH`.
- `RD_TURNAROUND`, 2: idle cycles between the last read-address bit and the first captured data bit. Must be ≥1.
- `GAP_CYCLES`, 2: idle cycles after each frame, before the next `strobe`. Must be ≥1.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `req_valid` input 1: a request is present.
- `req_ready` output 1: the block can accept a request; high only in IDLE.
- `req_write` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_BITS: register address.
- `req_wdata` input DATA_BITS: write data; ignored for reads.
- `rsp_valid` output 1: one-cycle pulse when a transaction completes (write or read).
- `rsp_rdata` output DATA_BITS: read data. Valid with `rsp_valid` on reads, holds until the next read completes, and is unchanged by writes.
- `busy` output 1: high in every state except IDLE.
- `ser_strobe` output 1: frame-start pulse to the slave.
- `ser_wr_en` output 1: mode to the slave (1 = write frame).
- `ser_din` output 1: serial data to the slave.
- `ser_dout` input 1: serial read data from the slave, synchronous to `clk`.

## Operation
- A request is accepted when `req_valid && req_ready` at a rising edge. On acceptance the block latches `req_write`, `req_addr` and `req_wdata`.
- States and transitions:
  - IDLE → START on accept.
  - START: one cycle with `ser_strobe`=1, `ser_din`=0 and `ser_wr_en` = latched `req_write`.
  - START → SHIFT.
  - SHIFT, write: drives DATA_BITS data bits LSB first, then ADDR_BITS address bits LSB first, one bit per cycle. N = DATA_BITS+ADDR_BITS.
  - SHIFT, read: drives ADDR_BITS address bits LSB first.
  - SHIFT (write) → DONE.
  - SHIFT (read) → TURN for RD_TURNAROUND cycles, `ser_din`=0 → CAPTURE.
  - CAPTURE: DATA_BITS cycles. Bit i of the read shift register = `ser_dout` sampled on the i-th CAPTURE edge, LSB first.
  - DONE: one cycle. `rsp_valid`=1. On reads, `rsp_rdata` is loaded at entry to DONE.
  - DONE → GAP for GAP_CYCLES cycles → IDLE.
- `ser_wr_en` is set in START. It then holds its value through IDLE until the next START, so the slave's post-frame write commit sees a stable mode.
- `ser_din`=0 in every state except SHIFT.
- A single bit counter is shared by SHIFT, TURN, CAPTURE and GAP. Its width is $clog2(max(N, RD_TURNAROUND, GAP_CYCLES)+1). The counter resets to 0 on every state change.
- There is no response backpressure. `rsp_valid` is a pulse, and the consumer must take it.
- An undefined state encoding returns to IDLE on the next cycle.

## Timing
- Reset values, applied asynchronously while `rst`=0:
  - 0: `req_ready`, `rsp_valid`, `busy`, `ser_strobe`, `ser_wr_en`, `ser_din`.
  - `rsp_rdata` = 0.
  - State = IDLE; all latches and counters = 0.
  - `req_ready` rises on the first edge after `rst` deasserts.
- Relative to acceptance edge T (cycle T):
  - START is cycle T+1.
  - Bit k is driven in cycle T+2+k.
- Write:
  - Last bit in cycle T+1+N.
  - DONE in cycle T+2+N.
  - `req_ready`=1 in cycle T+3+N+GAP_CYCLES.
- Read (A = ADDR_BITS, R = RD_TURNAROUND, D = DATA_BITS):
  - Address bits in cycles T+2..T+1+A.
  - CAPTURE in cycles T+2+A+R..T+1+A+R+D.
  - DONE in cycle T+2+A+R+D.
  - IDLE after GAP.
- Reset mid-frame: the frame is abandoned immediately and no `rsp_valid` is issued. The slave shares the same reset.
- `req_valid` while `req_ready`=0 is ignored. No request is queued.

## Test plan
- Reset: assert `rst`=0 mid-idle → all outputs 0. After release, `req_ready`=1 at the next edge and `busy`=0.
- Write addr 2, data 8'hA5 (defaults), accepted at T:
  - `ser_strobe`=1 only in T+1, with `ser_wr_en`=1.
  - `ser_din` in T+2..T+14 = 1,0,1,0,0,1,0,1,0,1,0,0,0.
  - `rsp_valid` in T+15 only.
  - `req_ready` back at T+18.
- Read addr 3, with the slave model returning 8'hCC:
  - `ser_wr_en`=0.
  - `ser_din` = 1,1,0,0,0 in T+2..T+6.
  - CAPTURE T+9..T+16.
  - `rsp_valid` and `rsp_rdata`=8'hCC at T+17.
  - `req_ready` at T+20.
- Back-to-back: `req_valid` held high with a write then a read.
  - The second request is accepted only at T+18.
  - No `ser_strobe` occurs in T+15..T+18.
  - `ser_wr_en` stays 1 until the read's START.
- Reset during SHIFT bit 4 of a write:
  - Outputs return to 0 within the reset assertion and there is no `rsp_valid`.
  - After release, a write of 8'h3C to addr 7 completes with the correct 13-bit sequence.
- Parameter sweep ADDR_BITS=6, DATA_BITS=16, RD_TURNAROUND=3, GAP_CYCLES=1: read of 16'hBEEF returns 16'hBEEF in DONE at T+27.
